// File: rtl/rta_wb_pkg.sv
// Shared types and constants for the ray-tracing write-back packer.
// The line struct is sized for the default 16-pixel line and 64-bit address.
package rta_wb_pkg;

    localparam int PIX_BITS         = 32;
    localparam int LINE_BYTES       = 64;
    localparam int DEF_PIX_PER_LINE = 16;
    localparam int DEF_ADDR_W       = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        DRAIN,
        DONE
    } wb_state_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]                addr;
        logic [DEF_PIX_PER_LINE*PIX_BITS-1:0] data;
        logic [DEF_PIX_PER_LINE*4-1:0]        be;
    } wb_line_t;

endpackage

// File: rtl/wb_line_fifo.sv
// Synchronous FIFO of finished DMA lines with an occupancy count.
// The caller never pushes when full; pops on an empty FIFO are ignored.
module wb_line_fifo
    import rta_wb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_line_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;

    assign pop_ok = pop && (count != '0);
    assign head   = mem[rd_ptr];

    // NOTE: storage carries no reset; an entry is only observed once count says it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_wb_packer.sv
// Merges tagged 32-bit pixels into byte-enabled cache lines and queues them
// as DMA write requests; flush closes the partial line and pulses done.
module pixel_wb_packer
    import rta_wb_pkg::*;
#(
    parameter int PIX_PER_LINE = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int ADDR_W       = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            base_addr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_pixel_id,
    input  logic [31:0]                  in_color,
    input  logic                         flush,
    output logic                         dma_wr_valid,
    input  logic                         dma_wr_ready,
    output logic [ADDR_W-1:0]            dma_wr_addr,
    output logic [PIX_PER_LINE*32-1:0]   dma_wr_data,
    output logic [PIX_PER_LINE*4-1:0]    dma_wr_be,
    output logic                         busy,
    output logic                         done,
    output logic [15:0]                  lines_written
);

    localparam int SLOT_W     = $clog2(PIX_PER_LINE);
    localparam int IDX_W      = 32 - SLOT_W;
    localparam int DATA_W     = PIX_PER_LINE * PIX_BITS;
    localparam int BE_W       = PIX_PER_LINE * 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int LINE_SHIFT = $clog2(LINE_BYTES);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } line_t;

    wb_state_e         state, state_nxt;
    logic [ADDR_W-1:0] base_q;

    logic              open_valid, open_valid_nxt;
    logic [IDX_W-1:0]  open_idx, open_idx_nxt;
    logic [DATA_W-1:0] open_data, open_data_nxt;
    logic [BE_W-1:0]   open_be, open_be_nxt;

    logic [SLOT_W-1:0] pix_slot;
    logic [IDX_W-1:0]  pix_idx;
    logic              accept;
    logic              merge_hit;
    logic [DATA_W-1:0] merged_data;
    logic [BE_W-1:0]   merged_be;

    logic              push;
    line_t             push_line;
    logic              pop;
    line_t             head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_space;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [IDX_W-1:0] idx);
        logic [ADDR_W+IDX_W+LINE_SHIFT-1:0] offset;
        offset = {{ADDR_W{1'b0}}, idx, {LINE_SHIFT{1'b0}}};
        return base_q + offset[ADDR_W-1:0];
    endfunction

    assign pix_slot   = in_pixel_id[SLOT_W-1:0];
    assign pix_idx    = in_pixel_id[31:SLOT_W];
    assign fifo_space = fifo_count < CNT_W'(FIFO_DEPTH);
    assign in_ready   = (state == ACCEPT) && fifo_space;
    assign accept     = in_valid && in_ready;
    assign merge_hit  = open_valid && (open_idx == pix_idx);

    assign dma_wr_valid = fifo_count != '0;
    assign pop          = dma_wr_valid && dma_wr_ready;
    assign dma_wr_addr  = dma_wr_valid ? head.addr : '0;
    assign dma_wr_data  = dma_wr_valid ? head.data : '0;
    assign dma_wr_be    = dma_wr_valid ? head.be   : '0;
    assign busy         = state != IDLE;
    assign done         = state == DONE;

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_nxt      = state;
        open_valid_nxt = open_valid;
        open_idx_nxt   = open_idx;
        open_data_nxt  = open_data;
        open_be_nxt    = open_be;
        push           = 1'b0;
        push_line      = '0;

        merged_data = merge_hit ? open_data : '0;
        merged_be   = merge_hit ? open_be   : '0;
        merged_data[int'(pix_slot)*PIX_BITS +: PIX_BITS] = in_color;
        merged_be[int'(pix_slot)*4 +: 4]                 = 4'hF;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt      = ACCEPT;
                    open_valid_nxt = 1'b0;
                end
            end
            ACCEPT: begin
                if (accept) begin
                    // A pixel for another line evicts the open one first.
                    if (open_valid && !merge_hit) begin
                        push      = 1'b1;
                        push_line = '{line_addr(open_idx), open_data, open_be};
                    end
                    if ((&merged_be) && !push) begin
                        push           = 1'b1;
                        push_line      = '{line_addr(pix_idx), merged_data, merged_be};
                        open_valid_nxt = 1'b0;
                    end else begin
                        open_valid_nxt = 1'b1;
                        open_idx_nxt   = pix_idx;
                        open_data_nxt  = merged_data;
                        open_be_nxt    = merged_be;
                    end
                end
                if (flush) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (open_valid) begin
                    if (fifo_space) begin
                        push           = 1'b1;
                        push_line      = '{line_addr(open_idx), open_data, open_be};
                        open_valid_nxt = 1'b0;
                    end
                end else if (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            base_q        <= '0;
            open_valid    <= 1'b0;
            lines_written <= '0;
        end else begin
            state      <= state_nxt;
            open_valid <= open_valid_nxt;
            if (state == IDLE && start) begin
                base_q        <= base_addr;
                lines_written <= '0;
            end else if (pop) begin
                lines_written <= lines_written + 16'd1;
            end
        end
    end

    // Open-line payload is qualified by open_valid and needs no reset.
    always_ff @(posedge clk) begin
        open_idx  <= open_idx_nxt;
        open_data <= open_data_nxt;
        open_be   <= open_be_nxt;
    end

    wb_line_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (line_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_line),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_pixel_wb_packer.sv
// Self-checking bench for pixel_wb_packer: directed scenarios plus random
// patches scored against a line-building reference model.
module tb_pixel_wb_packer;

    localparam int PPL   = 16;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [63:0]  base_addr = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_pixel_id = '0;
    logic [31:0]  in_color = '0;
    logic         flush = 1'b0;
    logic         dma_wr_valid;
    logic         dma_wr_ready = 1'b0;
    logic [63:0]  dma_wr_addr;
    logic [511:0] dma_wr_data;
    logic [63:0]  dma_wr_be;
    logic         busy;
    logic         done;
    logic [15:0]  lines_written;

    pixel_wb_packer #(.PIX_PER_LINE(PPL), .FIFO_DEPTH(DEPTH), .ADDR_W(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pixel_id   (in_pixel_id),
        .in_color      (in_color),
        .flush         (flush),
        .dma_wr_valid  (dma_wr_valid),
        .dma_wr_ready  (dma_wr_ready),
        .dma_wr_addr   (dma_wr_addr),
        .dma_wr_data   (dma_wr_data),
        .dma_wr_be     (dma_wr_be),
        .busy          (busy),
        .done          (done),
        .lines_written (lines_written)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;

    always @(posedge clk) cycle++;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // DMA ready: either a fixed level or random per cycle.
    bit ready_rand = 1'b0;
    bit ready_val  = 1'b0;
    always @(posedge clk) begin
        #1;
        dma_wr_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
    end

    // Reference model: expected write list built from accepted pixels.
    typedef struct {
        logic [63:0]  addr;
        logic [511:0] data;
        logic [63:0]  be;
    } wr_t;

    wr_t          exp_q[$];
    logic [63:0]  m_base = '0;
    logic [15:0]  m_lw = '0;
    int           m_occ = 0;
    bit           m_idle = 1'b1;
    bit           m_accepting = 1'b0;
    bit           mo_valid = 1'b0;
    logic [27:0]  mo_idx = '0;
    logic [511:0] mo_data = '0;
    logic [63:0]  mo_be = '0;
    int           flush_cycle = -10;
    int           last_pop_cycle = -10;

    task automatic model_push(input logic [27:0] idx, input logic [511:0] d, input logic [63:0] be);
        wr_t w;
        w.addr = m_base + 64'(idx) * 64;
        w.data = d;
        w.be   = be;
        exp_q.push_back(w);
        m_occ++;
    endtask

    task automatic model_accept(input logic [31:0] id, input logic [31:0] col);
        logic [27:0] idx;
        int          slot;
        idx  = id[31:4];
        slot = int'(id[3:0]);
        if (mo_valid && mo_idx != idx) begin
            model_push(mo_idx, mo_data, mo_be);
            mo_valid = 1'b0;
        end
        if (!mo_valid) begin
            mo_valid = 1'b1;
            mo_idx   = idx;
            mo_data  = '0;
            mo_be    = '0;
        end
        mo_data[slot*32 +: 32] = col;
        mo_be[slot*4 +: 4]     = 4'hF;
        if (mo_be == '1) begin
            model_push(mo_idx, mo_data, mo_be);
            mo_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        check("in_ready", in_ready, m_accepting && (m_occ < DEPTH));
        if (rst) begin
            exp_q.delete();
            m_lw        = '0;
            m_occ       = 0;
            m_idle      = 1'b1;
            m_accepting = 1'b0;
            mo_valid    = 1'b0;
        end else begin
            if (dma_wr_valid && dma_wr_ready) begin
                check("lw_before_pop", lines_written, m_lw);
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 1, 0);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("wr_addr", dma_wr_addr, w.addr);
                    check("wr_data", dma_wr_data, w.data);
                    check("wr_be", dma_wr_be, w.be);
                end
                m_lw++;
                m_occ--;
                last_pop_cycle = cycle;
            end
            if (in_valid && in_ready) model_accept(in_pixel_id, in_color);
            if (flush && m_accepting) begin
                if (mo_valid) model_push(mo_idx, mo_data, mo_be);
                mo_valid    = 1'b0;
                m_accepting = 1'b0;
                flush_cycle = cycle;
            end
            if (start && m_idle) begin
                m_base      = base_addr;
                m_lw        = '0;
                m_idle      = 1'b0;
                m_accepting = 1'b1;
            end
        end
    end

    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    task automatic do_start(input logic [63:0] b);
        start = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic send_pixel(input logic [31:0] id, input logic [31:0] col);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        in_valid    = 1'b1;
        in_pixel_id = id;
        in_color    = col;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 500);
        if (!acc) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int  n;
        bit  seen;
        int  exp_c;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 2000) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else n++;
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
        end else begin
            exp_c = (last_pop_cycle > flush_cycle) ? last_pop_cycle + 1 : flush_cycle + 2;
            check("done_cycle", cycle, exp_c);
            check("drain_left", exp_q.size(), 0);
            check("lw_at_done", lines_written, m_lw);
        end
        m_idle = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] b;
        logic [31:0] lo;
        int          npix;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid", dma_wr_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lw", lines_written, 0);
        check("rst_addr", dma_wr_addr, 0);
        check("rst_data", dma_wr_data, 0);
        check("rst_be", dma_wr_be, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ready_val = 1'b1;
        @(posedge clk); #1;

        // One full line in order.
        do_start(64'h1000);
        for (int i = 0; i < 16; i++) send_pixel(32'(i), 32'hA000_0000 + 32'(i));
        @(negedge clk);
        check("line_latency", dma_wr_valid, 1);
        @(negedge clk);
        check("lw_one", lines_written, 1);
        @(posedge clk); #1;
        do_flush();
        wait_done();

        // Two partial lines; pixel 20 arrives in the flush cycle.
        do_start(64'h1000);
        send_pixel(32'd3, 32'h1111_2222);
        flush = 1'b1;
        send_pixel(32'd20, 32'h3333_4444);
        flush = 1'b0;
        wait_done();
        check("two_lines_lw", lines_written, 2);

        // Same slot rewritten.
        do_start(64'h1000);
        send_pixel(32'd5, 32'hAAAA_AAAA);
        send_pixel(32'd5, 32'hBBBB_BBBB);
        do_flush();
        wait_done();
        check("rewrite_lw", lines_written, 1);

        // Backpressure: four lines fill the FIFO.
        ready_val = 1'b0;
        @(posedge clk); #1;
        do_start(64'h4000);
        for (int i = 0; i < 64; i++) send_pixel(32'(i), $urandom);
        in_valid    = 1'b1;
        in_pixel_id = 32'd64;
        in_color    = 32'hCAFE_0040;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_valid", dma_wr_valid, 1);
            check("stall_addr", dma_wr_addr, 64'h4000);
            if (exp_q.size() > 0) check("stall_data", dma_wr_data, exp_q[0].data);
        end
        @(posedge clk); #1;
        ready_val = 1'b1;
        for (int i = 64; i < 80; i++) send_pixel(32'(i), 32'hCAFE_0000 + 32'(i));
        do_flush();
        wait_done();
        check("stall_lw", lines_written, 5);

        // Empty flush; a start during DRAIN must be ignored.
        do_start(64'h8000);
        do_flush();
        start     = 1'b1;
        base_addr = 64'h9000;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        check("empty_lw", lines_written, 0);
        @(negedge clk);
        check("idle_after_done", busy, 0);
        @(posedge clk); #1;

        // Reset with two lines queued.
        ready_val = 1'b0;
        @(posedge clk); #1;
        do_start(64'h2000);
        for (int i = 0; i < 32; i++) send_pixel(32'(i), $urandom);
        @(negedge clk);
        check("pre_rst_valid", dma_wr_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", dma_wr_valid, 0);
        check("post_rst_busy", busy, 0);
        @(posedge clk); #1;
        ready_val = 1'b1;
        do_start(64'h3000);
        @(negedge clk);
        check("restart_lw", lines_written, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) send_pixel(32'(i), $urandom);
        do_flush();
        wait_done();
        check("restart_lw_end", lines_written, 1);

        // Random patches against the reference model.
        ready_rand = 1'b1;
        for (int p = 0; p < 8; p++) begin
            b  = (p == 7) ? 64'hFFFF_FFFF_FFFF_FFC0 : ({$urandom, $urandom} & ~64'h3F);
            lo = (p == 7) ? 32'd0 : (32'($urandom_range(0, 1 << 20)) << 4);
            do_start(b);
            npix = $urandom_range(10, 50);
            for (int i = 0; i < npix; i++) begin
                int g;
                if ($urandom_range(0, 3) == 0) begin
                    logic [31:0] ln;
                    ln = lo + (32'($urandom_range(0, 5)) << 4);
                    for (int s = 0; s < 16; s++) send_pixel(ln + 32'(s), $urandom);
                end else begin
                    send_pixel(lo + 32'($urandom_range(0, 95)), $urandom);
                end
                g = $urandom_range(0, 2);
                if (g > 0) begin
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
            do_flush();
            wait_done();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
